// File: rtl/hazard_forward_unit_pkg.sv
`default_nettype none
//==============================================================================
// Module   : hazard_forward_unit_pkg
// Brief    : Forward-select encodings, shadow-slot type and slot-match helper.
// Revision : 1.0
//==============================================================================
package hazard_forward_unit_pkg;

    // Slots carry the widest supported specifier; narrower ones are zero-extended.
    localparam int c_slot_rd_w = 8;

    localparam logic [1:0] FWD_IDEX   = 2'b00;
    localparam logic [1:0] FWD_EXMEM  = 2'b01;
    localparam logic [1:0] FWD_MEMWB  = 2'b10;
    localparam logic [1:0] FWD_WBLATE = 2'b11;

    typedef struct packed {
        logic                   valid;
        logic [c_slot_rd_w-1:0] rd;
        logic                   regwrite;
        logic                   isload;
    } slot_t;

    function automatic logic slot_match(input slot_t s, input logic [c_slot_rd_w-1:0] src);
        return s.valid && s.regwrite && (s.rd == src) && (s.rd != '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_forward_unit_slot_pipe.sv
`default_nettype none
//==============================================================================
// Module   : hazard_slot_pipe
// Brief    : Shadow-slot shift chain E->M->W(->X) with bubble insert into E.
//            Slot X exists only when HAZARD_WB_BYPASS_EN is defined.
// Revision : 1.0
//==============================================================================
module hazard_slot_pipe
    import hazard_forward_unit_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  i_bubble,
    input  slot_t i_slot,
    output slot_t o_slot_e,
    output slot_t o_slot_m,
    output slot_t o_slot_w
`ifdef HAZARD_WB_BYPASS_EN
    ,
    output slot_t o_slot_x
`endif
);

    slot_t r_slot_e;
    slot_t r_slot_m;
    slot_t r_slot_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot_e <= '0;
            r_slot_m <= '0;
            r_slot_w <= '0;
        end else begin
            r_slot_e <= i_bubble ? '0 : i_slot;
            r_slot_m <= r_slot_e;
            r_slot_w <= r_slot_m;
        end
    end

`ifdef HAZARD_WB_BYPASS_EN
    slot_t r_slot_x;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot_x <= '0;
        end else begin
            r_slot_x <= r_slot_w;
        end
    end

    assign o_slot_x = r_slot_x;
`endif

    assign o_slot_e = r_slot_e;
    assign o_slot_m = r_slot_m;
    assign o_slot_w = r_slot_w;

endmodule
`default_nettype wire

// File: rtl/hazard_forward_unit.sv
`default_nettype none
//==============================================================================
// Module   : hazard_forward_unit
// Brief    : EX operand forwarding selects, load-use stall, ID/EX flush and a
//            saturating stall counter. HAZARD_WB_BYPASS_EN adds a late bypass.
// Revision : 1.0
//==============================================================================
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  IDValid,
    input  logic [REG_ADDR_W-1:0] IDrs1,
    input  logic [REG_ADDR_W-1:0] IDrs2,
    input  logic                  IDUsesRs1,
    input  logic                  IDUsesRs2,
    input  logic [REG_ADDR_W-1:0] IDrd,
    input  logic                  IDRegWrite,
    input  logic                  IDIsLoad,
    input  logic [REG_ADDR_W-1:0] IDEXrs1,
    input  logic [REG_ADDR_W-1:0] IDEXrs2,
    input  logic                  BranchFlush,
    output logic [1:0]            ForwardA,
    output logic [1:0]            ForwardB,
    output logic                  Stall,
    output logic                  IDEXFlush,
    output logic [CNT_W-1:0]      StallCount
);

    slot_t                  w_id_slot;
    slot_t                  w_slot_e;
    slot_t                  w_slot_m;
    slot_t                  w_slot_w;
    logic [c_slot_rd_w-1:0] w_idrs1;
    logic [c_slot_rd_w-1:0] w_idrs2;
    logic [c_slot_rd_w-1:0] w_exrs1;
    logic [c_slot_rd_w-1:0] w_exrs2;
    logic [1:0]             w_fwd_a;
    logic [1:0]             w_fwd_b;
    logic                   w_load_use;
    logic                   w_stall;
    logic                   w_bubble;
    logic [CNT_W-1:0]       r_stall_cnt;

`ifdef HAZARD_WB_BYPASS_EN
    slot_t                  w_slot_x;
`endif

    always_comb begin
        w_idrs1   = '0;
        w_idrs2   = '0;
        w_exrs1   = '0;
        w_exrs2   = '0;
        w_id_slot = '0;
        w_idrs1[REG_ADDR_W-1:0]      = IDrs1;
        w_idrs2[REG_ADDR_W-1:0]      = IDrs2;
        w_exrs1[REG_ADDR_W-1:0]      = IDEXrs1;
        w_exrs2[REG_ADDR_W-1:0]      = IDEXrs2;
        w_id_slot.valid              = IDValid;
        w_id_slot.rd[REG_ADDR_W-1:0] = IDrd;
        w_id_slot.regwrite           = IDRegWrite;
        w_id_slot.isload             = IDIsLoad;
    end

    hazard_slot_pipe u_slot_pipe (
        .clk      (CLK),
        .rst      (RST),
        .i_bubble (w_bubble),
        .i_slot   (w_id_slot),
        .o_slot_e (w_slot_e),
        .o_slot_m (w_slot_m),
        .o_slot_w (w_slot_w)
`ifdef HAZARD_WB_BYPASS_EN
        ,
        .o_slot_x (w_slot_x)
`endif
    );

    // Later assignments override earlier ones, so the youngest match wins.
    always_comb begin
        w_fwd_a = FWD_IDEX;
        w_fwd_b = FWD_IDEX;
`ifdef HAZARD_WB_BYPASS_EN
        if (slot_match(w_slot_x, w_exrs1)) w_fwd_a = FWD_WBLATE;
        if (slot_match(w_slot_x, w_exrs2)) w_fwd_b = FWD_WBLATE;
`endif
        if (slot_match(w_slot_w, w_exrs1)) w_fwd_a = FWD_MEMWB;
        if (slot_match(w_slot_w, w_exrs2)) w_fwd_b = FWD_MEMWB;
        if (slot_match(w_slot_m, w_exrs1)) w_fwd_a = FWD_EXMEM;
        if (slot_match(w_slot_m, w_exrs2)) w_fwd_b = FWD_EXMEM;
    end

    always_comb begin
        w_load_use = IDValid && w_slot_e.isload &&
                     ((IDUsesRs1 && slot_match(w_slot_e, w_idrs1)) ||
                      (IDUsesRs2 && slot_match(w_slot_e, w_idrs2)));
        w_stall    = w_load_use && !BranchFlush;
        w_bubble   = w_stall || BranchFlush;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign ForwardA   = w_fwd_a;
    assign ForwardB   = w_fwd_b;
    assign Stall      = w_stall;
    assign IDEXFlush  = w_bubble;
    assign StallCount = r_stall_cnt;

    // Only slot E's load flag matters; older slots' flags ride along unread.
`ifdef HAZARD_WB_BYPASS_EN
    logic w_unused;
    assign w_unused = w_slot_m.isload ^ w_slot_w.isload ^ w_slot_x.isload;
`else
    logic w_unused;
    assign w_unused = w_slot_m.isload ^ w_slot_w.isload;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_forward_unit.sv
`default_nettype none
//==============================================================================
// Module   : tb_hazard_forward_unit
// Brief    : Scoreboard bench for hazard_forward_unit (honours HAZARD_WB_BYPASS_EN).
// Revision : 1.0
//==============================================================================
module tb_hazard_forward_unit;

    localparam int c_cnt_w   = 4;
    localparam int c_cnt_max = 15;
`ifdef HAZARD_WB_BYPASS_EN
    localparam int BYP = 3;
`else
    localparam int BYP = 0;
`endif

    logic               CLK;
    logic               RST;
    logic               IDValid;
    logic [4:0]         IDrs1;
    logic [4:0]         IDrs2;
    logic               IDUsesRs1;
    logic               IDUsesRs2;
    logic [4:0]         IDrd;
    logic               IDRegWrite;
    logic               IDIsLoad;
    logic [4:0]         IDEXrs1;
    logic [4:0]         IDEXrs2;
    logic               BranchFlush;
    logic [1:0]         ForwardA;
    logic [1:0]         ForwardB;
    logic               Stall;
    logic               IDEXFlush;
    logic [c_cnt_w-1:0] StallCount;
    logic [9:0]         w_obs;

    typedef struct {
        int v, rs1, rs2, u1, u2, rd, rw, ld;
        int xr1, xr2, bf, rst;
        int chk, fa, fb, st, fl;
    } step_t;

    typedef struct {
        string      name;
        int         idx;
        logic [9:0] val;
        bit         chk;
    } exp_t;

    exp_t             sb[$];
    int               checks   = 0;
    int               failures = 0;
    logic [c_cnt_w-1:0] exp_cnt = '0;

    hazard_forward_unit #(
        .REG_ADDR_W (5),
        .CNT_W      (c_cnt_w)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .IDValid     (IDValid),
        .IDrs1       (IDrs1),
        .IDrs2       (IDrs2),
        .IDUsesRs1   (IDUsesRs1),
        .IDUsesRs2   (IDUsesRs2),
        .IDrd        (IDrd),
        .IDRegWrite  (IDRegWrite),
        .IDIsLoad    (IDIsLoad),
        .IDEXrs1     (IDEXrs1),
        .IDEXrs2     (IDEXrs2),
        .BranchFlush (BranchFlush),
        .ForwardA    (ForwardA),
        .ForwardB    (ForwardB),
        .Stall       (Stall),
        .IDEXFlush   (IDEXFlush),
        .StallCount  (StallCount)
    );

    assign w_obs = {ForwardA, ForwardB, Stall, IDEXFlush, StallCount};

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic step_t mk(input int v, rs1, rs2, u1, u2, rd, rw, ld,
                                 xr1, xr2, bf, rst, chk, fa, fb, st, fl);
        step_t s;
        s = '{v, rs1, rs2, u1, u2, rd, rw, ld, xr1, xr2, bf, rst, chk, fa, fb, st, fl};
        return s;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drives one cycle of stimulus, queues its expectation and advances the counter model.
    task automatic apply(input step_t s, input string name, input int idx);
        exp_t e;
        IDValid     = 1'(s.v);
        IDrs1       = 5'(s.rs1);
        IDrs2       = 5'(s.rs2);
        IDUsesRs1   = 1'(s.u1);
        IDUsesRs2   = 1'(s.u2);
        IDrd        = 5'(s.rd);
        IDRegWrite  = 1'(s.rw);
        IDIsLoad    = 1'(s.ld);
        IDEXrs1     = 5'(s.xr1);
        IDEXrs2     = 5'(s.xr2);
        BranchFlush = 1'(s.bf);
        RST         = 1'(s.rst);
        e.name = name;
        e.idx  = idx;
        e.val  = {2'(s.fa), 2'(s.fb), 1'(s.st), 1'(s.fl), exp_cnt};
        e.chk  = (s.chk != 0);
        sb.push_back(e);
        if (s.rst != 0)
            exp_cnt = '0;
        else if (s.st != 0 && exp_cnt != c_cnt_w'(c_cnt_max))
            exp_cnt = exp_cnt + 1'b1;
    endtask

    task automatic drain();
        IDValid = 0; IDrs1 = 0; IDrs2 = 0; IDUsesRs1 = 0; IDUsesRs2 = 0;
        IDrd = 0; IDRegWrite = 0; IDIsLoad = 0; IDEXrs1 = 0; IDEXrs2 = 0;
        BranchFlush = 0; RST = 0;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        step_t t[$];
        exp_t  e;
        t.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,1, 0,0,0,0,0));
        t.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,1, 0,0,0,0,0));
        t.push_back(mk(0,0,0,0,0,0,0,0, 5,5,0,0, 1,0,0,0,0));
        t.push_back(mk(1,3,4,1,1,6,1,0, 3,4,0,0, 1,0,0,0,0));
        foreach (t[i]) begin
            apply(t[i], "reset", i);
            #1;
            e = sb.pop_front();
            if (e.chk) begin
                checks++;
                if (w_obs !== e.val) begin
                    failures++;
                    $display("FAIL %s[%0d] got=%b expected=%b", e.name, e.idx, w_obs, e.val);
                end
            end
            tick();
        end
    endtask

    task automatic test_fwd_ex_mem();
        step_t t[$];
        exp_t  e;
        t.push_back(mk(1,0,0,0,0,5,1,0, 0,0,0,0, 0,0,0,0,0));
        t.push_back(mk(0,0,0,0,0,0,0,0, 5,0,0,0, 1,0,0,0,0));
        t.push_back(mk(0,0,0,0,0,0,0,0, 5,0,0,0, 1,1,0,0,0));
        t.push_back(mk(0,0,0,0,0,0,0,0, 5,5,0,0, 1,2,2,0,0));
        t.push_back(mk(0,0,0,0,0,0,0,0, 5,5,0,0, 1,BYP,BYP,0,0));
        t.push_back(mk(0,0,0,0,0,0,0,0, 5,5,0,0, 1,0,0,0,0));
        drain();
        foreach (t[i]) begin
            apply(t[i], "fwd_ex_mem", i);
            #1;
            e = sb.pop_front();
            if (e.chk) begin
                checks++;
                if (w_obs !== e.val) begin
                    failures++;
                    $display("FAIL %s[%0d] got=%b expected=%b", e.name, e.idx, w_obs, e.val);
                end
            end
            tick();
        end
    endtask

    task automatic test_fwd_priority();
        step_t t[$];
        exp_t  e;
        t.push_back(mk(1,0,0,0,0,5,1,0, 0,0,0,0, 0,0,0,0,0));
        t.push_back(mk(1,0,0,0,0,5,1,0, 0,0,0,0, 0,0,0,0,0));
        t.push_back(mk(0,0,0,0,0,0,0,0, 6,5,0,0, 1,0,1,0,0));
        t.push_back(mk(0,0,0,0,0,0,0,0, 0,5,0,0, 1,0,1,0,0));
        t.push_back(mk(0,0,0,0,0,0,0,0, 5,5,0,0, 1,2,2,0,0));
        drain();
        foreach (t[i]) begin
            apply(t[i], "fwd_priority", i);
            #1;
            e = sb.pop_front();
            if (e.chk) begin
                checks++;
                if (w_obs !== e.val) begin
                    failures++;
                    $display("FAIL %s[%0d] got=%b expected=%b", e.name, e.idx, w_obs, e.val);
                end
            end
            tick();
        end
    endtask

    task automatic test_load_use();
        step_t t[$];
        exp_t  e;
        t.push_back(mk(1,0,0,0,0,7,1,1, 0,0,0,0, 0,0,0,0,0));
        t.push_back(mk(1,3,7,1,1,9,1,0, 0,0,0,0, 1,0,0,1,1));
        t.push_back(mk(1,3,7,1,1,9,1,0, 0,7,0,0, 1,0,1,0,0));
        t.push_back(mk(0,0,0,0,0,0,0,0, 0,7,0,0, 1,0,2,0,0));
        t.push_back(mk(1,0,0,0,0,8,1,1, 0,0,0,0, 0,0,0,0,0));
        t.push_back(mk(1,8,8,1,0,0,0,0, 0,0,0,0, 1,0,0,1,1));
        t.push_back(mk(1,8,8,1,0,0,0,0, 0,0,0,0, 1,0,0,0,0));
        t.push_back(mk(1,0,0,0,0,10,1,1, 0,0,0,0, 0,0,0,0,0));
        t.push_back(mk(1,10,10,0,0,0,0,0, 0,0,0,0, 1,0,0,0,0));
        t.push_back(mk(1,0,0,0,0,11,1,1, 0,0,0,0, 0,0,0,0,0));
        t.push_back(mk(0,11,11,1,1,0,0,0, 0,0,0,0, 1,0,0,0,0));
        t.push_back(mk(1,0,0,0,0,12,1,0, 0,0,0,0, 0,0,0,0,0));
        t.push_back(mk(1,12,0,1,0,0,0,0, 0,0,0,0, 1,0,0,0,0));
        drain();
        foreach (t[i]) begin
            apply(t[i], "load_use", i);
            #1;
            e = sb.pop_front();
            if (e.chk) begin
                checks++;
                if (w_obs !== e.val) begin
                    failures++;
                    $display("FAIL %s[%0d] got=%b expected=%b", e.name, e.idx, w_obs, e.val);
                end
            end
            tick();
        end
    endtask

    task automatic test_branch();
        step_t t[$];
        exp_t  e;
        t.push_back(mk(1,0,0,0,0,7,1,1, 0,0,0,0, 0,0,0,0,0));
        t.push_back(mk(1,0,7,0,1,12,1,0, 0,0,1,0, 1,0,0,0,1));
        t.push_back(mk(0,0,0,0,0,0,0,0, 12,7,0,0, 1,0,1,0,0));
        t.push_back(mk(0,0,0,0,0,0,0,0, 12,7,0,0, 1,0,2,0,0));
        t.push_back(mk(0,0,0,0,0,0,0,0, 0,0,1,0, 1,0,0,0,1));
        drain();
        foreach (t[i]) begin
            apply(t[i], "branch", i);
            #1;
            e = sb.pop_front();
            if (e.chk) begin
                checks++;
                if (w_obs !== e.val) begin
                    failures++;
                    $display("FAIL %s[%0d] got=%b expected=%b", e.name, e.idx, w_obs, e.val);
                end
            end
            tick();
        end
    endtask

    task automatic test_x0();
        step_t t[$];
        exp_t  e;
        t.push_back(mk(1,0,0,0,0,0,1,0, 0,0,0,0, 0,0,0,0,0));
        t.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,0));
        t.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0, 1,0,0,0,0));
        t.push_back(mk(1,0,0,0,0,0,1,1, 0,0,0,0, 0,0,0,0,0));
        t.push_back(mk(1,0,0,1,1,5,1,0, 0,0,0,0, 1,0,0,0,0));
        drain();
        foreach (t[i]) begin
            apply(t[i], "x0", i);
            #1;
            e = sb.pop_front();
            if (e.chk) begin
                checks++;
                if (w_obs !== e.val) begin
                    failures++;
                    $display("FAIL %s[%0d] got=%b expected=%b", e.name, e.idx, w_obs, e.val);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_stall_bypass();
        step_t t[$];
        exp_t  e;
        t.push_back(mk(1,0,0,0,0,7,1,1, 0,0,0,0, 0,0,0,0,0));
        t.push_back(mk(1,0,7,0,1,9,1,0, 0,0,0,1, 1,0,0,1,1));
        t.push_back(mk(0,0,0,0,0,0,0,0, 7,7,0,0, 1,0,0,0,0));
        t.push_back(mk(0,0,0,0,0,0,0,0, 7,7,0,0, 1,0,0,0,0));
        t.push_back(mk(1,0,0,0,0,9,1,0, 0,0,0,0, 0,0,0,0,0));
        t.push_back(mk(0,0,0,0,0,0,0,0, 9,0,0,0, 1,0,0,0,0));
        t.push_back(mk(0,0,0,0,0,0,0,0, 9,0,0,0, 1,1,0,0,0));
        t.push_back(mk(0,0,0,0,0,0,0,0, 9,0,0,0, 1,2,0,0,0));
        t.push_back(mk(0,0,0,0,0,0,0,0, 9,9,0,0, 1,BYP,BYP,0,0));
        drain();
        foreach (t[i]) begin
            apply(t[i], "reset_stall_bypass", i);
            #1;
            e = sb.pop_front();
            if (e.chk) begin
                checks++;
                if (w_obs !== e.val) begin
                    failures++;
                    $display("FAIL %s[%0d] got=%b expected=%b", e.name, e.idx, w_obs, e.val);
                end
            end
            tick();
        end
    endtask

    task automatic test_saturate();
        step_t t[$];
        exp_t  e;
        for (int k = 0; k < 17; k++) begin
            t.push_back(mk(1,0,0,0,0,7,1,1, 0,0,0,0, 0,0,0,0,0));
            t.push_back(mk(1,0,7,0,1,0,0,0, 0,0,0,0, 1,0,0,1,1));
        end
        t.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0, 1,0,0,0,0));
        drain();
        foreach (t[i]) begin
            apply(t[i], "saturate", i);
            #1;
            e = sb.pop_front();
            if (e.chk) begin
                checks++;
                if (w_obs !== e.val) begin
                    failures++;
                    $display("FAIL %s[%0d] got=%b expected=%b", e.name, e.idx, w_obs, e.val);
                end
            end
            tick();
        end
    endtask

    initial begin
        RST = 1'b1;
        IDValid = 0; IDrs1 = 0; IDrs2 = 0; IDUsesRs1 = 0; IDUsesRs2 = 0;
        IDrd = 0; IDRegWrite = 0; IDIsLoad = 0; IDEXrs1 = 0; IDEXrs2 = 0;
        BranchFlush = 0;
        test_reset();
        test_fwd_ex_mem();
        test_fwd_priority();
        test_load_use();
        test_branch();
        test_x0();
        test_reset_stall_bypass();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_forward_unit.md
HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
- REQ-001 Parameter REG_ADDR_W SHALL be: REG_ADDR_W, default 5, register-specifier width.
- REQ-002 Parameter CNT_W SHALL be: CNT_W, default 32, stall performance-counter width.
- REQ-003 Ports SHALL be:
  - CLK  in  1  clock, all state on rising edge.
  - RST  in  1  synchronous active-high reset.
  - IDValid  in  1  ID stage holds a real instruction.
  - IDrs1 / IDrs2  in  REG_ADDR_W  sources of the ID-stage instruction.
  - IDUsesRs1 / IDUsesRs2  in  1  ID-stage instruction reads that source.
  - IDrd  in  REG_ADDR_W  destination of the ID-stage instruction.
  - IDRegWrite  in  1  ID-stage instruction writes IDrd.
  - IDIsLoad  in  1  ID-stage instruction is a load.
  - IDEXrs1 / IDEXrs2  in  REG_ADDR_W  sources held in the ID/EX register.
  - BranchFlush  in  1  branch/jump resolved taken in EX this cycle.
  - ForwardA / ForwardB  out  2  operand-source select for EX.
  - Stall  out  1  hold PC and IF/ID.
  - IDEXFlush  out  1  load a bubble into ID/EX.
  - StallCount  out  CNT_W  load-use stall cycles since reset.
- REQ-004 Clocking and reset SHALL be one clock, CLK; RST synchronous, active-high.

Function
- REQ-005 The block SHALL keep three shadow slots E, M, W, each {valid, rd, regwrite, isload}, tracking instructions in EX, MEM, WB.
- REQ-006 Each rising edge: W<=M, M<=E, E<=ID fields with valid=IDValid, or a bubble (valid=0) when Stall or BranchFlush is 1.
- REQ-007 Slot match for source s SHALL need valid=1, regwrite=1, rd==s, rd!=0.
- REQ-008 ForwardA SHALL be combinational for IDEXrs1, priority M-match -> 2'b01, else W-match -> 2'b10, else 2'b00.
- REQ-009 ForwardB SHALL apply the same rule to IDEXrs2.
- REQ-010 Stall SHALL be 1 when all of the following hold:
  - IDValid=1.
  - E is a valid load with regwrite=1 and rd!=0.
  - E.rd matches IDrs1 with IDUsesRs1=1, or IDrs2 with IDUsesRs2=1.
  - BranchFlush=0.
- REQ-011 Stall SHALL last exactly one cycle per load-use hazard, because the bubble inserted into E clears the condition.
- REQ-012 IDEXFlush SHALL be Stall OR BranchFlush.
- REQ-013 If BranchFlush and a load-use hazard coincide, BranchFlush SHALL win: Stall=0, IDEXFlush=1, no count.
- REQ-014 StallCount SHALL increment by 1 on each rising edge where Stall=1 and SHALL saturate at all-ones.
- REQ-015 ForwardA/ForwardB SHALL depend only on IDEXrs1/IDEXrs2 and slot state, never on Stall.

Reset
- REQ-016 On RST=1 at a rising edge:
  - All slot valids, StallCount, and every registered field SHALL be cleared to 0.
  - ForwardA/ForwardB SHALL be 2'b00 and Stall=0 the next cycle.
- REQ-017 RST SHALL override every simultaneous event, including a stall or flush in progress.

Configuration
- REQ-018 Macro HAZARD_WB_BYPASS_EN SHALL control a fourth slot X, holding the retired instruction (X<=W each edge).
  - Defined: if no M- or W-match, an X-match SHALL give ForwardA/B=2'b11, serving register files without write-before-read.
  - Undefined: slot X SHALL be absent and 2'b11 SHALL never be driven.

Structure
- REQ-019 A shared package SHALL hold:
  - Forward-select constants FWD_IDEX=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10, FWD_WBLATE=2'b11.
  - The slot struct typedef.
- REQ-020 Sub-module hazard_slot_pipe SHALL implement the shadow-slot shift chain and the bubble insert.
  - Compare, stall and counter logic SHALL stay in the top.

Verification
- REQ-021 The bench SHALL cover these scenarios:
  - Scenario 1: add x5 in E, next cycle IDEXrs1=5 -> ForwardA=01, ForwardB=00.
  - Scenario 2: writers of x5 in M and in W, IDEXrs2=5 -> ForwardB=01 (M priority).
  - Scenario 3: lw x7 in E, ID reads x7 as rs2 -> Stall=1 and IDEXFlush=1 for exactly 1 cycle, StallCount 0->1; next cycle ForwardB=01.
  - Scenario 4: lw x7 in E, ID reads x7, BranchFlush=1 same cycle -> Stall=0, IDEXFlush=1, StallCount unchanged.
  - Scenario 5: writer to x0 in M, IDEXrs1=0 -> ForwardA=00; a load to x0 in E -> Stall=0.
  - Scenario 6: RST=1 during Stall -> next cycle all outputs 0, StallCount=0; with HAZARD_WB_BYPASS_EN, writer of x9 three cycles back -> ForwardA=11.
